// File: rtl/dff_reg.sv
// Parameterisable rising-edge register chain (STAGES deep, WIDTH wide) with asynchronous active-high reset.
// Optional macro DFF_REG_QN_OUT_EN adds an inverted output QN appended after Q.
module dff_reg #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] D,
    input  logic             CLK,
    input  logic             RESET_N,   // active-high despite the name
    output logic [WIDTH-1:0] Q
`ifdef DFF_REG_QN_OUT_EN
    ,
    output logic [WIDTH-1:0] QN
`endif
);

    logic [WIDTH-1:0] stage [STAGES];

    // NOTE: every stage is reset, not only the output stage, so a reset
    // mid-stream discards all in-flight data instead of letting it drain out.
    always_ff @(posedge CLK or posedge RESET_N) begin
        if (RESET_N) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RESET_VALUE;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage take its neighbour's
            // pre-edge value; blocking ones would collapse the chain to one stage.
            stage[0] <= D;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign Q = stage[STAGES-1];

`ifdef DFF_REG_QN_OUT_EN
    assign QN = ~stage[STAGES-1];
`endif

endmodule

// File: tb/tb_dff_reg.sv
// Directed bench for dff_reg: a default 1-bit DFF and an 8-bit, 3-stage chain with reset value 8'hA5.
// Build with DFF_REG_QN_OUT_EN defined to also exercise the QN output.
`timescale 1ns/100ps
module tb_dff_reg;

    logic       clk = 1'b0;
    logic       r1  = 1'b0;
    logic       d1  = 1'b0;
    logic       q1;
    logic       r8  = 1'b1;
    logic [7:0] d8  = 8'h00;
    logic [7:0] q8;
`ifdef DFF_REG_QN_OUT_EN
    logic       qn1;
    logic [7:0] qn8;
`endif

    int checks   = 0;
    int failures = 0;

    always #2 clk = ~clk;   // 4 ns period, rising edges at 2, 6, 10, ...

    dff_reg u_bit (
        .D       (d1),
        .CLK     (clk),
        .RESET_N (r1),
        .Q       (q1)
`ifdef DFF_REG_QN_OUT_EN
        ,
        .QN      (qn1)
`endif
    );

    dff_reg #(
        .WIDTH       (8),
        .STAGES      (3),
        .RESET_VALUE (8'hA5)
    ) u_chain (
        .D       (d8),
        .CLK     (clk),
        .RESET_N (r8),
        .Q       (q8)
`ifdef DFF_REG_QN_OUT_EN
        ,
        .QN      (qn8)
`endif
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Land 1 ns before the next rising edge.
    task automatic before_edge();
        @(negedge clk);
        #1;
    endtask

    // Land 1 ns after the next rising edge.
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- 1-bit DFF ----------------
        after_edge();
        r1 = 1'b1;                      // assert between edges
        #0.5;
        check("async_rst", {7'd0, q1}, 8'h00);
`ifdef DFF_REG_QN_OUT_EN
        check("qn_rst", {7'd0, qn1}, 8'h01);
`endif
        d1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            after_edge();
            check("rst_hold", {7'd0, q1}, 8'h00);
        end

        // Deassertion alone changes nothing.
        r1 = 1'b0;
        d1 = 1'b0;
        #0.5;
        check("deassert_nochg", {7'd0, q1}, 8'h00);

        before_edge(); d1 = 1'b1;
        after_edge();
        check("capture_1", {7'd0, q1}, 8'h01);
`ifdef DFF_REG_QN_OUT_EN
        check("qn_capture_1", {7'd0, qn1}, 8'h00);
`endif
        before_edge(); d1 = 1'b0;
        after_edge();
        check("capture_0", {7'd0, q1}, 8'h00);

        // Reset overrides data while the clock keeps running.
        before_edge(); d1 = 1'b1;
        after_edge();
        check("pre_rst_q1", {7'd0, q1}, 8'h01);
        r1 = 1'b1;
        #0.5;
        check("rst_over_data", {7'd0, q1}, 8'h00);
        for (int i = 0; i < 2; i++) begin
            after_edge();
            check("rst_over_hold", {7'd0, q1}, 8'h00);
        end
        before_edge(); r1 = 1'b0;
        after_edge();
        check("first_capture", {7'd0, q1}, 8'h01);

        // Glitches between edges are ignored.
        before_edge(); d1 = 1'b0;
        after_edge();
        #0.5 d1 = 1'b1;
        #0.5 d1 = 1'b0;
        #0.5;
        check("glitch_low", {7'd0, q1}, 8'h00);
        after_edge();
        check("glitch_low_edge", {7'd0, q1}, 8'h00);
        before_edge(); d1 = 1'b1;
        after_edge();
        #0.5 d1 = 1'b0;
        #0.5 d1 = 1'b1;
        after_edge();
        check("glitch_high_edge", {7'd0, q1}, 8'h01);

        // Reset coinciding with a clock edge: reset wins.
        @(posedge clk);
        r1 = 1'b1;
        #1;
        check("rst_edge_race", {7'd0, q1}, 8'h00);
        r1 = 1'b0;

        // ---------------- 8-bit, 3-stage chain ----------------
        check("chain_rst", q8, 8'hA5);
`ifdef DFF_REG_QN_OUT_EN
        check("chain_qn_rst", qn8, 8'h5A);
`endif
        after_edge();
        r8 = 1'b0;
        #0.5;
        check("chain_deassert", q8, 8'hA5);

        before_edge(); d8 = 8'h01;
        after_edge(); check("lat_e1", q8, 8'hA5);
        before_edge(); d8 = 8'h02;
        after_edge(); check("lat_e2", q8, 8'hA5);
        before_edge(); d8 = 8'h03;
        after_edge(); check("lat_e3", q8, 8'h01);
        before_edge(); d8 = 8'hFF;
        after_edge(); check("lat_e4", q8, 8'h02);
        before_edge(); d8 = 8'h80;
        after_edge(); check("lat_e5", q8, 8'h03);
        after_edge(); check("lat_e6", q8, 8'hFF);
`ifdef DFF_REG_QN_OUT_EN
        check("chain_qn", qn8, 8'h00);
`endif

        // Mid-stream reset flushes every stage.
        r8 = 1'b1;
        #0.5;
        check("chain_mid_rst", q8, 8'hA5);
        d8 = 8'h3C;
        after_edge(); check("chain_rst_hold", q8, 8'hA5);
        before_edge(); r8 = 1'b0;
        after_edge(); check("flush_e1", q8, 8'hA5);
        after_edge(); check("flush_e2", q8, 8'hA5);
        after_edge(); check("flush_e3", q8, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
